pb_ram_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for the shared single-port block RAM (1-cycle read latency) that sits between the two PicoBlaze processors.
- Each PicoBlaze-side port decoder raises a held request. The arbiter:
  - serialises accesses onto the RAM's en/we/addr/din pins,
  - returns read data with a per-requester valid pulse.
- Replaces direct port_id-bit wiring of the RAM enables, so both processors can share the store without collisions.

---
 rtl/pb_ram_arbiter_if.sv | 28 ++
 rtl/pb_ram_arbiter.sv | 82 ++++++++
 tb/tb_pb_ram_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pb_ram_arbiter_if.sv
// Bus bundle between the two PicoBlaze port decoders, the arbiter and the
// shared single-port block RAM.
interface pb_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 8
);
  logic                  req0, we0, gnt0, rvalid0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  req1, we1, gnt1, rvalid1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ram_en, ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din, ram_dout;
  logic                  busy;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_dout,
    output gnt0, rvalid0, gnt1, rvalid1, rdata, ram_en, ram_we, ram_addr, ram_din, busy
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_dout,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata, ram_en, ram_we, ram_addr, ram_din, busy
  );
endinterface

// File: rtl/pb_ram_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a shared single-port RAM
// with 1-cycle read latency: 2 cycles per write, 3 cycles per read.
module pb_ram_arbiter #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  pb_ram_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RDWAIT = 2'd2} state_t;

  state_t                          state, state_nxt;
  logic [1:0]                      req, we;
  logic [1:0][ADDR_WIDTH-1:0]      addr;
  logic [1:0][DATA_WIDTH-1:0]      wdata;
  logic                            ptr, sel, take;
  logic                            lat_id, lat_we;
  logic [ADDR_WIDTH-1:0]           lat_addr;
  logic [DATA_WIDTH-1:0]           lat_din;
  logic [1:0]                      rvalid_q;
  logic [DATA_WIDTH-1:0]           rdata_q;

  assign req   = {bus.req1, bus.req0};
  assign we    = {bus.we1, bus.we0};
  assign addr  = {bus.addr1, bus.addr0};
  assign wdata = {bus.wdata1, bus.wdata0};

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  // Requests are only looked at in IDLE; contention resolved by ptr.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    sel       = ptr;
    case (state)
      IDLE: if (|req) begin
        take      = 1'b1;
        sel       = (&req) ? ptr : req[1];
        state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = lat_we ? IDLE : RDWAIT;
      RDWAIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ptr      <= 1'b0;
      lat_id   <= 1'b0;
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_din  <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (take) begin
        lat_id   <= sel;
        lat_we   <= we[sel];
        lat_addr <= addr[sel];
        lat_din  <= wdata[sel];
        ptr      <= ~sel;
      end
      rvalid_q <= (state == RDWAIT) ? (2'b01 << lat_id) : 2'b00;
      if (state == RDWAIT) rdata_q <= bus.ram_dout;
    end

  // RAM address/data come straight from the latch so they hold between accesses.
  assign bus.ram_en   = (state == ISSUE);
  assign bus.ram_we   = (state == ISSUE) && lat_we;
  assign bus.ram_addr = lat_addr;
  assign bus.ram_din  = lat_din;
  assign bus.gnt0     = (state == ISSUE) && !lat_id;
  assign bus.gnt1     = (state == ISSUE) &&  lat_id;
  assign bus.rvalid0  = rvalid_q[0];
  assign bus.rvalid1  = rvalid_q[1];
  assign bus.rdata    = rdata_q;
  assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_pb_ram_arbiter.sv
// Bench for pb_ram_arbiter: directed vector table, hand sequences for reset,
// and random traffic against a transaction-scheduling reference model.
module tb_pb_ram_arbiter;
  localparam int AW = 1;
  localparam int DW = 8;
  localparam int NRAND = 3000;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  pb_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  pb_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // Single-port RAM, 1-cycle read latency
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk)
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      else            bus.ram_dout <= mem[bus.ram_addr];
    end

  typedef struct packed {
    logic r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
  } in_t;
  typedef struct packed {
    logic g0, g1, en, we; logic [AW-1:0] addr; logic [DW-1:0] din;
    logic v0, v1; logic [DW-1:0] rdata; logic busy;
  } out_t;
  typedef struct packed { in_t i; out_t o; } vec_t;

  localparam out_t ZERO = '0;
  localparam out_t ALL  = '1;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[$];

  function automatic in_t vi(int r0, int w0, int a0, int d0, int r1, int w1, int a1, int d1);
    in_t v;
    v.r0 = r0[0]; v.w0 = w0[0]; v.a0 = AW'(a0); v.d0 = DW'(d0);
    v.r1 = r1[0]; v.w1 = w1[0]; v.a1 = AW'(a1); v.d1 = DW'(d1);
    return v;
  endfunction

  function automatic out_t vo(int g0, int g1, int en, int we, int addr, int din,
                              int v0, int v1, int rdata, int busy);
    out_t o;
    o.g0 = g0[0]; o.g1 = g1[0]; o.en = en[0]; o.we = we[0];
    o.addr = AW'(addr); o.din = DW'(din);
    o.v0 = v0[0]; o.v1 = v1[0]; o.rdata = DW'(rdata); o.busy = busy[0];
    return o;
  endfunction

  task automatic add(input in_t i, input out_t o);
    tbl.push_back({i, o});
  endtask

  task automatic drive(input in_t v);
    bus.req0 = v.r0; bus.we0 = v.w0; bus.addr0 = v.a0; bus.wdata0 = v.d0;
    bus.req1 = v.r1; bus.we1 = v.w1; bus.addr1 = v.a1; bus.wdata1 = v.d1;
  endtask

  function automatic out_t sample();
    out_t s;
    s.g0 = bus.gnt0; s.g1 = bus.gnt1; s.en = bus.ram_en; s.we = bus.ram_we;
    s.addr = bus.ram_addr; s.din = bus.ram_din;
    s.v0 = bus.rvalid0; s.v1 = bus.rvalid1; s.rdata = bus.rdata; s.busy = bus.busy;
    return s;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("g0=%b g1=%b en=%b we=%b addr=%h din=%h v0=%b v1=%b rdata=%h busy=%b",
                     o.g0, o.g1, o.en, o.we, o.addr, o.din, o.v0, o.v1, o.rdata, o.busy);
  endfunction

  task automatic check(input string nm, input out_t act, input out_t exp, input out_t mask);
    n_tests++;
    if ((act & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s: got {%s} expected {%s}", nm, fmt(act), fmt(exp & mask));
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      @(posedge clk); #1;
      check($sformatf("vec%0d", k), sample(), tbl[k].o, ALL);
      drive(tbl[k].i);
    end
  endtask

  // Reference model: schedules transaction effects into a small ring of future cycles
  bit            ev_iss [8];
  bit            ev_iid [8];
  bit            ev_iwe [8];
  logic [AW-1:0] ev_ia  [8];
  logic [DW-1:0] ev_id  [8];
  bit            ev_rv  [8];
  bit            ev_rid [8];
  logic [DW-1:0] ev_rd  [8];
  bit            ev_rk  [8];
  logic [DW-1:0] mmem   [2**AW];
  bit            mknown [2**AW];

  task automatic random_phase();
    int            next_free = 0;
    bit            ptr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_din = '0, m_rdata = '0;
    bit            m_rk = 1'b1;
    bit            rq [2];
    logic          rw [2];
    logic [AW-1:0] ra [2];
    logic [DW-1:0] rd [2];
    for (int k = 0; k < 8; k++) begin ev_iss[k] = 0; ev_rv[k] = 0; end
    for (int k = 0; k < 2**AW; k++) mknown[k] = 0;
    for (int k = 0; k < 2; k++) begin rq[k] = 0; rw[k] = 0; ra[k] = '0; rd[k] = '0; end
    for (int c = 0; c < NRAND; c++) begin
      int   s = c % 8;
      out_t e = ZERO;
      out_t m = ALL;
      @(posedge clk); #1;
      if (ev_iss[s]) begin
        e.g0 = !ev_iid[s]; e.g1 = ev_iid[s]; e.en = 1'b1; e.we = ev_iwe[s];
        m_addr = ev_ia[s]; m_din = ev_id[s];
      end
      if (ev_rv[s]) begin
        e.v0 = !ev_rid[s]; e.v1 = ev_rid[s]; m_rdata = ev_rd[s]; m_rk = ev_rk[s];
      end
      e.addr = m_addr; e.din = m_din; e.rdata = m_rdata;
      e.busy = (c < next_free);
      if (!m_rk) m.rdata = '0;
      check($sformatf("rand%0d", c), sample(), e, m);
      ev_iss[s] = 0; ev_rv[s] = 0;
      for (int r = 0; r < 2; r++)
        if (!rq[r] || (r == 0 ? e.g0 : e.g1)) begin
          rq[r] = ($urandom_range(0, 3) != 0);
          rw[r] = 1'($urandom_range(0, 1));
          ra[r] = AW'($urandom);
          rd[r] = DW'($urandom);
        end
      drive({rq[0], rw[0], ra[0], rd[0], rq[1], rw[1], ra[1], rd[1]});
      if (c >= next_free && (rq[0] || rq[1])) begin
        bit id = (rq[0] && rq[1]) ? ptr : rq[1];
        int s1 = (c + 1) % 8;
        ptr = !id;
        ev_iss[s1] = 1; ev_iid[s1] = id; ev_iwe[s1] = rw[id];
        ev_ia[s1] = ra[id]; ev_id[s1] = rd[id];
        if (rw[id]) begin
          mmem[ra[id]] = rd[id]; mknown[ra[id]] = 1;
          next_free = c + 2;
        end else begin
          int s3 = (c + 3) % 8;
          ev_rv[s3] = 1; ev_rid[s3] = id; ev_rd[s3] = mmem[ra[id]]; ev_rk[s3] = mknown[ra[id]];
          next_free = c + 3;
        end
      end
    end
  endtask

  initial begin
    int nA;
    in_t idle, rb;
    idle = '0;
    drive(idle);
    #2 reset_n = 1'b0;
    #1 check("reset", sample(), ZERO, ALL);

    // Write then read by requester 0
    add(vi(1,1,1,'hA5, 0,0,0,0), vo(0,0,0,0,0,'h00,0,0,'h00,0));
    add(vi(1,0,1,'h00, 0,0,0,0), vo(1,0,1,1,1,'hA5,0,0,'h00,1));
    add(vi(1,0,1,'h00, 0,0,0,0), vo(0,0,0,0,1,'hA5,0,0,'h00,0));
    add(idle,                    vo(1,0,1,0,1,'h00,0,0,'h00,1));
    add(idle,                    vo(0,0,0,0,1,'h00,0,0,'h00,1));
    add(idle,                    vo(0,0,0,0,1,'h00,1,0,'hA5,0));
    // Requester 0 served, then contention: requester 1 wins next
    add(vi(1,0,1,0, 0,0,0,0),    vo(0,0,0,0,1,'h00,0,0,'hA5,0));
    add(vi(1,0,1,0, 1,0,1,0),    vo(1,0,1,0,1,'h00,0,0,'hA5,1));
    add(vi(1,0,1,0, 1,0,1,0),    vo(0,0,0,0,1,'h00,0,0,'hA5,1));
    add(vi(1,0,1,0, 1,0,1,0),    vo(0,0,0,0,1,'h00,1,0,'hA5,0));
    add(vi(1,0,1,0, 0,0,0,0),    vo(0,1,1,0,1,'h00,0,0,'hA5,1));
    add(vi(1,0,1,0, 0,0,0,0),    vo(0,0,0,0,1,'h00,0,0,'hA5,1));
    add(idle,                    vo(0,0,0,0,1,'h00,0,1,'hA5,0));
    // Back-to-back writes by requester 1
    add(vi(0,0,0,0, 1,1,1,'h01), vo(0,0,0,0,1,'h00,0,0,'hA5,0));
    add(vi(0,0,0,0, 1,1,1,'h02), vo(0,1,1,1,1,'h01,0,0,'hA5,1));
    add(vi(0,0,0,0, 1,1,1,'h02), vo(0,0,0,0,1,'h01,0,0,'hA5,0));
    add(vi(0,0,0,0, 1,1,1,'h03), vo(0,1,1,1,1,'h02,0,0,'hA5,1));
    add(vi(0,0,0,0, 1,1,1,'h03), vo(0,0,0,0,1,'h02,0,0,'hA5,0));
    add(vi(0,0,0,0, 1,1,1,'h04), vo(0,1,1,1,1,'h03,0,0,'hA5,1));
    add(vi(0,0,0,0, 1,1,1,'h04), vo(0,0,0,0,1,'h03,0,0,'hA5,0));
    add(idle,                    vo(0,1,1,1,1,'h04,0,0,'hA5,1));
    // Idle hold after the write to addr 1
    for (int k = 0; k < 10; k++) add(idle, vo(0,0,0,0,1,'h04,0,0,'hA5,0));
    // Preload addr 0 for the contention run
    add(vi(1,1,0,'h3C, 0,0,0,0), vo(0,0,0,0,1,'h04,0,0,'hA5,0));
    add(idle,                    vo(1,0,1,1,0,'h3C,0,0,'hA5,1));
    add(idle,                    vo(0,0,0,0,0,'h3C,0,0,'hA5,0));
    nA = tbl.size();
    // Contention straight after reset: 0,1,0 with 3-cycle spacing
    rb = vi(1,0,0,0, 1,0,0,0);
    add(rb,   vo(0,0,0,0,0,0,0,0,'h00,0));
    add(rb,   vo(1,0,1,0,0,0,0,0,'h00,1));
    add(rb,   vo(0,0,0,0,0,0,0,0,'h00,1));
    add(rb,   vo(0,0,0,0,0,0,1,0,'h3C,0));
    add(rb,   vo(0,1,1,0,0,0,0,0,'h3C,1));
    add(rb,   vo(0,0,0,0,0,0,0,0,'h3C,1));
    add(rb,   vo(0,0,0,0,0,0,0,1,'h3C,0));
    add(rb,   vo(1,0,1,0,0,0,0,0,'h3C,1));
    add(rb,   vo(0,0,0,0,0,0,0,0,'h3C,1));
    add(idle, vo(0,0,0,0,0,0,1,0,'h3C,0));
    add(idle, vo(0,0,0,0,0,0,0,0,'h3C,0));

    @(posedge clk); #3 reset_n = 1'b1;
    run_rows(0, nA);
    #2 reset_n = 1'b0;
    #1 check("reset_mid", sample(), ZERO, ALL);
    @(posedge clk); #3 reset_n = 1'b1;
    run_rows(nA, tbl.size());

    // Asynchronous reset in the RDWAIT cycle of a read
    drive(vi(1,0,0,0, 0,0,0,0));
    @(posedge clk); #1 check("t5_issue", sample(), vo(1,0,1,0,0,0,0,0,'h3C,1), ALL);
    drive(idle);
    @(posedge clk); #1 check("t5_rdwait", sample(), vo(0,0,0,0,0,0,0,0,'h3C,1), ALL);
    #3 reset_n = 1'b0;
    #1 check("t5_async", sample(), ZERO, ALL);
    @(posedge clk); #2 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 check($sformatf("t5_norv%0d", k), sample(), ZERO, ALL);
    end
    drive(rb);
    @(posedge clk); #1 check("t5_gnt0", sample(), vo(1,0,1,0,0,0,0,0,'h00,1), ALL);
    drive(idle);
    @(posedge clk); #1 check("t5_wait", sample(), vo(0,0,0,0,0,0,0,0,'h00,1), ALL);
    @(posedge clk); #1 check("t5_rv", sample(), vo(0,0,0,0,0,0,1,0,'h3C,0), ALL);

    #2 reset_n = 1'b0;
    @(posedge clk); #3 reset_n = 1'b1;
    random_phase();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
